// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX hazard/interlock logic: register index width,
// the hard-wired zero register and the trap FSM state type.
package dlx_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } trap_state_t;

endpackage

// File: rtl/dlx_load_scoreboard.sv
// Shift-register scoreboard of in-flight load destinations, with a dual-port
// compare that flags ID source operands still waiting on a load.
module dlx_load_scoreboard
    import dlx_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ins_vld,
    input  logic [REG_W-1:0] i_ins_dst,
    input  logic [REG_W-1:0] i_rs1,
    input  logic             i_uses_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_uses_rs2,
    output logic             o_hit_rs1,
    output logic             o_hit_rs2
);

    logic [LOAD_LAT-1:0] r_vld;
    logic [REG_W-1:0]    r_dst [LOAD_LAT];
    logic                w_match1;
    logic                w_match2;

    for (genvar g = 0; g < LOAD_LAT; g++) begin : g_slot
        if (g == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!rst_n) r_vld[g] <= 1'b0;
                else        r_vld[g] <= i_ins_vld;
            end
            always_ff @(posedge clk) r_dst[g] <= i_ins_dst;
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst_n) r_vld[g] <= 1'b0;
                else        r_vld[g] <= r_vld[g-1];
            end
            always_ff @(posedge clk) r_dst[g] <= r_dst[g-1];
        end
    end

    always_comb begin
        w_match1 = 1'b0;
        w_match2 = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (r_vld[i] && (r_dst[i] == i_rs1)) w_match1 = 1'b1;
            if (r_vld[i] && (r_dst[i] == i_rs2)) w_match2 = 1'b1;
        end
    end

    // r0 never carries a dependency, even if a stale entry names it
    assign o_hit_rs1 = i_uses_rs1 & (i_rs1 != REG_ZERO) & w_match1;
    assign o_hit_rs2 = i_uses_rs2 & (i_rs2 != REG_ZERO) & w_match2;

endmodule

// File: rtl/dlx_hazard_unit.sv
// ID-stage interlock and squash controller: load-use stalls from a scoreboard,
// wrong-path squashing after taken branches, and a trap drain/halt FSM.
module dlx_hazard_unit
    import dlx_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int KILL_SLOTS   = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_is_load,
    input  logic [REG_W-1:0]  id_dst,
    input  logic              id_taken,
    input  logic              id_is_trap,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              squash_id,
    output logic              redirect,
    output logic              halted,
    output logic [STAT_W-1:0] stall_count
);

    localparam int KILL_W  = $clog2(KILL_SLOTS + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    trap_state_t        r_state;
    logic [KILL_W-1:0]  r_kill_cnt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [STAT_W-1:0]  r_stall_count;

    logic w_hit_rs1;
    logic w_hit_rs2;
    logic w_run;
    logic w_kill_active;
    logic w_eligible;
    logic w_hazard;
    logic w_issue;
    logic w_sb_vld;

    // Eligibility already excludes DRAIN/HALT and squashed slots, so the
    // priority state > squash > hazard > issue falls out of the gating.
    assign w_run         = (r_state == ST_RUN);
    assign w_kill_active = (r_kill_cnt != '0);
    assign w_eligible    = rst_n & id_valid & w_run & ~w_kill_active;
    assign w_hazard      = w_eligible & (w_hit_rs1 | w_hit_rs2);
    assign w_issue       = w_eligible & ~(w_hit_rs1 | w_hit_rs2);
    assign w_sb_vld      = w_issue & id_is_load & (id_dst != REG_ZERO);

    dlx_load_scoreboard #(
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ins_vld  (w_sb_vld),
        .i_ins_dst  (id_dst),
        .i_rs1      (id_rs1),
        .i_uses_rs1 (id_uses_rs1),
        .i_rs2      (id_rs2),
        .i_uses_rs2 (id_uses_rs2),
        .o_hit_rs1  (w_hit_rs1),
        .o_hit_rs2  (w_hit_rs2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_drain_cnt   <= '0;
            r_kill_cnt    <= '0;
            r_stall_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue && id_is_trap) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    if (r_drain_cnt == DRAIN_W'(1)) r_state <= ST_HALT;
                end
                default: r_state <= ST_HALT;
            endcase

            // A trap supersedes any branch on the same issue
            if (w_issue && id_is_trap)     r_kill_cnt <= '0;
            else if (w_issue && id_taken)  r_kill_cnt <= KILL_W'(KILL_SLOTS);
            else if (w_kill_active)        r_kill_cnt <= r_kill_cnt - KILL_W'(1);

            if (w_hazard && (r_stall_count != '1))
                r_stall_count <= r_stall_count + STAT_W'(1);
        end
    end

    assign stall_if    = rst_n & (~w_run | w_hazard);
    assign squash_id   = rst_n & (~w_run | w_kill_active);
    assign bubble_ex   = rst_n & (~w_run | w_kill_active | w_hazard);
    assign redirect    = w_issue & id_taken & ~id_is_trap;
    assign halted      = rst_n & (r_state == ST_HALT);
    assign stall_count = rst_n ? r_stall_count : '0;

endmodule

// File: tb/tb_dlx_hazard_unit.sv
// Directed bench for dlx_hazard_unit: two instances (LOAD_LAT=1 and 2) share
// the ID-stage stimulus; expected values are hand-derived per cycle.
module tb_dlx_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_is_load;
    logic [4:0] id_dst;
    logic       id_taken;
    logic       id_is_trap;

    logic        a_stall_if, a_bubble_ex, a_squash_id, a_redirect, a_halted;
    logic [2:0]  a_stall_count;
    logic        b_stall_if, b_bubble_ex, b_squash_id, b_redirect, b_halted;
    logic [15:0] b_stall_count;

    int n_checks = 0;
    int n_fails  = 0;

    dlx_hazard_unit #(
        .LOAD_LAT     (1),
        .KILL_SLOTS   (2),
        .DRAIN_CYCLES (3),
        .STAT_W       (3)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_is_load  (id_is_load),
        .id_dst      (id_dst),
        .id_taken    (id_taken),
        .id_is_trap  (id_is_trap),
        .stall_if    (a_stall_if),
        .bubble_ex   (a_bubble_ex),
        .squash_id   (a_squash_id),
        .redirect    (a_redirect),
        .halted      (a_halted),
        .stall_count (a_stall_count)
    );

    dlx_hazard_unit #(
        .LOAD_LAT     (2),
        .KILL_SLOTS   (1),
        .DRAIN_CYCLES (3),
        .STAT_W       (16)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_is_load  (id_is_load),
        .id_dst      (id_dst),
        .id_taken    (id_taken),
        .id_is_trap  (id_is_trap),
        .stall_if    (b_stall_if),
        .bubble_ex   (b_bubble_ex),
        .squash_id   (b_squash_id),
        .redirect    (b_redirect),
        .halted      (b_halted),
        .stall_count (b_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_ins(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic ld,
                           input logic [4:0] dst, input logic tk, input logic tp);
        id_valid    = v;
        id_rs1      = rs1;
        id_uses_rs1 = u1;
        id_rs2      = rs2;
        id_uses_rs2 = u2;
        id_is_load  = ld;
        id_dst      = dst;
        id_taken    = tk;
        id_is_trap  = tp;
    endtask

    task automatic nop();
        set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [4:0] dst);
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, dst, 1'b0, 1'b0);
    endtask

    task automatic alu(input logic [4:0] dst, input logic [4:0] rs1, input logic [4:0] rs2);
        set_ins(1'b1, rs1, 1'b1, rs2, 1'b1, 1'b0, dst, 1'b0, 1'b0);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        next_cycle();

        // Outputs forced low while reset is asserted, even with a trap in ID
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        sample();
        check("rst_stall", int'(a_stall_if), 0);
        check("rst_squash", int'(a_squash_id), 0);
        check("rst_redirect", int'(a_redirect), 0);
        check("rst_bubble", int'(a_bubble_ex), 0);
        next_cycle();

        rst_n = 1'b1;
        nop();
        sample();
        check("post_rst_halted", int'(a_halted), 0);
        check("post_rst_stall", int'(a_stall_if), 0);
        check("post_rst_count", int'(a_stall_count), 0);
        next_cycle();

        // LW r5; ADD r6,r5,r7
        load(5'd5);
        sample();
        check("lw_issue_stall", int'(a_stall_if), 0);
        check("lw_issue_bubble", int'(a_bubble_ex), 0);
        next_cycle();
        alu(5'd6, 5'd5, 5'd7);
        sample();
        check("lu1_stall_a", int'(a_stall_if), 1);
        check("lu1_bubble_a", int'(a_bubble_ex), 1);
        check("lu1_squash_a", int'(a_squash_id), 0);
        check("lu2_stall_b_c1", int'(b_stall_if), 1);
        next_cycle();
        sample();
        check("lu1_release_a", int'(a_stall_if), 0);
        check("lu1_count_a", int'(a_stall_count), 1);
        check("lu2_stall_b_c2", int'(b_stall_if), 1);
        next_cycle();
        sample();
        check("lu2_release_b", int'(b_stall_if), 0);
        check("lu2_count_b", int'(b_stall_count), 2);
        next_cycle();
        nop();
        next_cycle();
        next_cycle();

        // LW r0; ADD r6,r0,r7 never stalls
        load(5'd0);
        next_cycle();
        alu(5'd6, 5'd0, 5'd7);
        sample();
        check("r0_stall_a", int'(a_stall_if), 0);
        check("r0_stall_b", int'(b_stall_if), 0);
        next_cycle();
        nop();
        next_cycle();
        next_cycle();

        // LW r3; ADD r8,r9,r10; SUB r4,r3,r1
        load(5'd3);
        next_cycle();
        alu(5'd8, 5'd9, 5'd10);
        sample();
        check("gap_unrel_b", int'(b_stall_if), 0);
        next_cycle();
        alu(5'd4, 5'd3, 5'd1);
        sample();
        check("gap_stall_b", int'(b_stall_if), 1);
        check("gap_nostall_a", int'(a_stall_if), 0);
        next_cycle();
        sample();
        check("gap_release_b", int'(b_stall_if), 0);
        check("gap_count_b", int'(b_stall_count), 3);
        next_cycle();
        nop();
        next_cycle();
        next_cycle();

        // Taken branch, then a trap and a load in the two killed slots
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        sample();
        check("br_redirect", int'(a_redirect), 1);
        check("br_squash", int'(a_squash_id), 0);
        next_cycle();
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        sample();
        check("sq1_squash", int'(a_squash_id), 1);
        check("sq1_bubble", int'(a_bubble_ex), 1);
        check("sq1_stall", int'(a_stall_if), 0);
        check("sq1_redirect", int'(a_redirect), 0);
        next_cycle();
        load(5'd9);
        sample();
        check("sq2_squash", int'(a_squash_id), 1);
        check("sq2_redirect", int'(a_redirect), 0);
        next_cycle();
        alu(5'd1, 5'd9, 5'd0);
        sample();
        check("post_sq_squash", int'(a_squash_id), 0);
        check("post_sq_nosb", int'(a_stall_if), 0);
        next_cycle();
        nop();
        sample();
        check("post_sq_notrap", int'(a_stall_if), 0);
        check("post_sq_halted", int'(a_halted), 0);
        next_cycle();

        // Trap together with id_taken: no redirect, drain 3, then halt
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        sample();
        check("trap_redirect", int'(a_redirect), 0);
        check("trap_issue_stall", int'(a_stall_if), 0);
        next_cycle();
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("drain_stall", int'(a_stall_if), 1);
            check("drain_squash", int'(a_squash_id), 1);
            check("drain_bubble", int'(a_bubble_ex), 1);
            check("drain_halted", int'(a_halted), 0);
            check("drain_redirect", int'(a_redirect), 0);
            next_cycle();
        end
        sample();
        check("halt_rise", int'(a_halted), 1);
        check("halt_stall", int'(a_stall_if), 1);
        next_cycle();
        sample();
        check("halt_hold", int'(a_halted), 1);
        check("halt_squash", int'(a_squash_id), 1);
        next_cycle();

        // Reset mid-drain
        rst_n = 1'b0;
        nop();
        sample();
        check("rst_halt_out", int'(a_halted), 0);
        next_cycle();
        rst_n = 1'b1;
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        next_cycle();
        nop();
        sample();
        check("in_drain", int'(a_stall_if), 1);
        next_cycle();
        rst_n = 1'b0;
        sample();
        check("rst_drain_squash", int'(a_squash_id), 0);
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("rd_halted", int'(a_halted), 0);
        check("rd_stall", int'(a_stall_if), 0);
        check("rd_squash", int'(a_squash_id), 0);
        check("rd_count", int'(a_stall_count), 0);
        next_cycle();
        sample();
        check("rd_run", int'(a_stall_if), 0);
        next_cycle();

        // Reset with a scoreboard entry live
        load(5'd5);
        next_cycle();
        rst_n = 1'b0;
        alu(5'd6, 5'd5, 5'd7);
        sample();
        check("rst_sb_held", int'(a_stall_if), 0);
        next_cycle();
        rst_n = 1'b1;
        sample();
        check("rst_sb_a", int'(a_stall_if), 0);
        check("rst_sb_b", int'(b_stall_if), 0);
        next_cycle();
        nop();
        next_cycle();
        next_cycle();

        // Nine load-use stalls into a 3-bit counter
        for (int i = 0; i < 9; i++) begin
            load(5'd2);
            next_cycle();
            alu(5'd6, 5'd2, 5'd0);
            sample();
            check("sat_stall", int'(a_stall_if), 1);
            next_cycle();
            next_cycle();
            if (i == 2) begin
                sample();
                check("sat_mid", int'(a_stall_count), 3);
                next_cycle();
            end
        end
        nop();
        sample();
        check("sat_final", int'(a_stall_count), 7);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
